// File: rtl/l2_port_isolate_ctrl.sv
// l2_port_isolate_ctrl
//
// Quiesces and isolates individual L2 AXI ports. Each port tracks its
// outstanding writes and reads. On an isolation request the port stops
// accepting new AW/AR requests, waits for the outstanding responses to
// return, and then acknowledges isolation. B and R responses are never
// gated. A separate saturating counter tallies ECC error pulses.
//
// Optional feature: define L2_ISOLATE_TIMEOUT_EN to add a per-port drain
// timer. A port that has drained for TimeoutCycles cycles is then forced
// into isolation and its timeout_o flag is set. Without the macro a drain
// waits indefinitely and timeout_o is tied to 0.
//
// Ports (all per-port vectors are NumPort wide):
//   clk_i, rst_ni                  clock; asynchronous active-low reset
//   isolate_i / isolated_o         isolation request / acknowledge
//   timeout_o                      sticky: port was isolated by timeout
//   slv_aw_valid_i, mst_aw_ready_i AW handshake inputs (gated)
//   mst_aw_valid_o, slv_aw_ready_o AW handshake outputs (gated)
//   slv_ar_valid_i, mst_ar_ready_i AR handshake inputs (gated)
//   mst_ar_valid_o, slv_ar_ready_o AR handshake outputs (gated)
//   b_valid_i, b_ready_i           observed B handshake
//   r_valid_i, r_ready_i, r_last_i observed R handshake
//   ecc_error_i, ecc_clear_i       ECC error pulse / counter clear
//   ecc_count_o                    saturating ECC error count
module l2_port_isolate_ctrl #(
    parameter int NumPort       = 2,
    parameter int MaxTrans      = 8,
    parameter int TimeoutCycles = 1024,
    parameter int EccCntWidth   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumPort-1:0]     isolate_i,
    output logic [NumPort-1:0]     isolated_o,
    output logic [NumPort-1:0]     timeout_o,
    input  logic [NumPort-1:0]     slv_aw_valid_i,
    input  logic [NumPort-1:0]     mst_aw_ready_i,
    output logic [NumPort-1:0]     mst_aw_valid_o,
    output logic [NumPort-1:0]     slv_aw_ready_o,
    input  logic [NumPort-1:0]     slv_ar_valid_i,
    input  logic [NumPort-1:0]     mst_ar_ready_i,
    output logic [NumPort-1:0]     mst_ar_valid_o,
    output logic [NumPort-1:0]     slv_ar_ready_o,
    input  logic [NumPort-1:0]     b_valid_i,
    input  logic [NumPort-1:0]     b_ready_i,
    input  logic [NumPort-1:0]     r_valid_i,
    input  logic [NumPort-1:0]     r_ready_i,
    input  logic [NumPort-1:0]     r_last_i,
    input  logic                   ecc_error_i,
    input  logic                   ecc_clear_i,
    output logic [EccCntWidth-1:0] ecc_count_o
);

    localparam int              CntW   = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ISOLATED
    } state_e;

    for (genvar p = 0; p < NumPort; p++) begin : g_port
        state_e          state_q, state_d;
        logic [CntW-1:0] wr_cnt_q, rd_cnt_q;
        logic            aw_allow, ar_allow;
        logic            aw_hs, ar_hs, b_hs, r_hs;
        logic            cnt_zero, expire;

        // Requests pass through combinationally while the port runs and
        // the channel still has room for another outstanding transaction.
        assign aw_allow = (state_q == RUN) && (wr_cnt_q < CntMax);
        assign ar_allow = (state_q == RUN) && (rd_cnt_q < CntMax);

        assign mst_aw_valid_o[p] = slv_aw_valid_i[p] & aw_allow;
        assign slv_aw_ready_o[p] = mst_aw_ready_i[p] & aw_allow;
        assign mst_ar_valid_o[p] = slv_ar_valid_i[p] & ar_allow;
        assign slv_ar_ready_o[p] = mst_ar_ready_i[p] & ar_allow;

        assign aw_hs = mst_aw_valid_o[p] & mst_aw_ready_i[p];
        assign ar_hs = mst_ar_valid_o[p] & mst_ar_ready_i[p];
        assign b_hs  = b_valid_i[p] & b_ready_i[p];
        // A read is complete only on its last beat.
        assign r_hs  = r_valid_i[p] & r_ready_i[p] & r_last_i[p];

        // Registered values only: a counter reaching zero this cycle
        // isolates the port one cycle later.
        assign cnt_zero = (wr_cnt_q == '0) && (rd_cnt_q == '0);

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                // A response at count zero is spurious and is dropped.
                if (aw_hs && !b_hs) begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                end else if (!aw_hs && b_hs && (wr_cnt_q != '0)) begin
                    wr_cnt_q <= wr_cnt_q - 1'b1;
                end
                if (ar_hs && !r_hs) begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end else if (!ar_hs && r_hs && (rd_cnt_q != '0)) begin
                    rd_cnt_q <= rd_cnt_q - 1'b1;
                end
            end
        end

`ifdef L2_ISOLATE_TIMEOUT_EN
        localparam int              TmrW    = $clog2(TimeoutCycles + 1);
        localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

        logic [TmrW-1:0] timer_q;
        logic            timeout_q;

        // The timer reads 0 in the first DRAIN cycle, so expiry falls on
        // the TimeoutCycles-th cycle spent draining.
        assign expire = (state_q == DRAIN) && (timer_q == TmrLast);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                timer_q   <= '0;
                timeout_q <= 1'b0;
            end else begin
                timer_q <= (state_q == DRAIN) ? timer_q + 1'b1 : '0;
                if ((state_q == ISOLATED) && !isolate_i[p]) begin
                    timeout_q <= 1'b0;
                end else if (expire && isolate_i[p] && !cnt_zero) begin
                    timeout_q <= 1'b1;
                end
            end
        end

        assign timeout_o[p] = timeout_q;
`else
        assign expire       = 1'b0;
        assign timeout_o[p] = 1'b0;
`endif

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= RUN;
            end else begin
                state_q <= state_d;
            end
        end

        // NOTE: state_d gets its default before the case so that no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            unique case (state_q)
                RUN: begin
                    if (isolate_i[p]) state_d = DRAIN;
                end
                DRAIN: begin
                    // Withdrawing the request wins over completing the drain.
                    if (!isolate_i[p])          state_d = RUN;
                    else if (cnt_zero || expire) state_d = ISOLATED;
                end
                ISOLATED: begin
                    if (!isolate_i[p]) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end

        assign isolated_o[p] = (state_q == ISOLATED);

`ifndef SYNTHESIS
        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(b_hs && !aw_hs && (wr_cnt_q == '0)))
                    else $warning("port %0d: B response with no outstanding write dropped", p);
                assert (!(r_hs && !ar_hs && (rd_cnt_q == '0)))
                    else $warning("port %0d: R last with no outstanding read dropped", p);
            end
        end
`endif
    end

    // A clear coinciding with an error leaves that error counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ecc_count_o <= '0;
        end else if (ecc_clear_i) begin
            ecc_count_o <= EccCntWidth'(ecc_error_i);
        end else if (ecc_error_i && (ecc_count_o != '1)) begin
            ecc_count_o <= ecc_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_port_isolate_ctrl.sv
// Self-checking bench for l2_port_isolate_ctrl (NumPort=2, MaxTrans=8,
// TimeoutCycles=16, EccCntWidth=4). Each test pushes its expected result
// into a queue as stimulus is applied and pops it when the DUT output is
// sampled. Inputs change 1 time unit after the rising edge.
module tb_l2_port_isolate_ctrl;

    localparam int NumPort       = 2;
    localparam int MaxTrans      = 8;
    localparam int TimeoutCycles = 16;
    localparam int EccW          = 4;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NumPort-1:0] isolate_i, isolated_o, timeout_o;
    logic [NumPort-1:0] slv_aw_valid_i, mst_aw_ready_i, mst_aw_valid_o, slv_aw_ready_o;
    logic [NumPort-1:0] slv_ar_valid_i, mst_ar_ready_i, mst_ar_valid_o, slv_ar_ready_o;
    logic [NumPort-1:0] b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic               ecc_error_i, ecc_clear_i;
    logic [EccW-1:0]    ecc_count_o;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, exp;

    l2_port_isolate_ctrl #(
        .NumPort      (NumPort),
        .MaxTrans     (MaxTrans),
        .TimeoutCycles(TimeoutCycles),
        .EccCntWidth  (EccW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .isolate_i     (isolate_i),
        .isolated_o    (isolated_o),
        .timeout_o     (timeout_o),
        .slv_aw_valid_i(slv_aw_valid_i),
        .mst_aw_ready_i(mst_aw_ready_i),
        .mst_aw_valid_o(mst_aw_valid_o),
        .slv_aw_ready_o(slv_aw_ready_o),
        .slv_ar_valid_i(slv_ar_valid_i),
        .mst_ar_ready_i(mst_ar_ready_i),
        .mst_ar_valid_o(mst_ar_valid_o),
        .slv_ar_ready_o(slv_ar_ready_o),
        .b_valid_i     (b_valid_i),
        .b_ready_i     (b_ready_i),
        .r_valid_i     (r_valid_i),
        .r_ready_i     (r_ready_i),
        .r_last_i      (r_last_i),
        .ecc_error_i   (ecc_error_i),
        .ecc_clear_i   (ecc_clear_i),
        .ecc_count_o   (ecc_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want normal completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        isolate_i      = '0;
        slv_aw_valid_i = '0; mst_aw_ready_i = '0;
        slv_ar_valid_i = '0; mst_ar_ready_i = '0;
        b_valid_i = '0; b_ready_i = '0;
        r_valid_i = '0; r_ready_i = '0; r_last_i = '0;
        ecc_error_i = 1'b0; ecc_clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        got = 32'(isolated_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rst_isolated: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(timeout_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rst_timeout: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(ecc_count_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rst_ecc: got %0d want %0d", got, exp); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    // Three writes (isolate raised alongside the third), three B's back.
    task automatic test_drain_isolate();
        slv_aw_valid_i[0] = 1'b1; mst_aw_ready_i[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            isolate_i[0] = (i == 2);
            exp_q.push_back(32'd1);
            #1;
            got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
            if (got !== exp) $display("FAIL drain_aw_accept[%0d]: got %0d want %0d", i, got, exp); else n_pass++;
            tick();
        end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL drain_aw_ready_block: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(mst_aw_valid_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL drain_aw_valid_block: got %0d want %0d", got, exp); else n_pass++;
        slv_aw_valid_i[0] = 1'b0;
        b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
        repeat (3) tick();
        b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
        exp_q.push_back(32'd0);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL iso_not_early: got %0d want %0d", got, exp); else n_pass++;
        tick();
        exp_q.push_back(32'd1);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL iso_after_b: got %0d want %0d", got, exp); else n_pass++;
        slv_aw_valid_i[0] = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL iso_aw_block: got %0d want %0d", got, exp); else n_pass++;
        slv_aw_valid_i[0] = 1'b0; isolate_i[0] = 1'b0;
        tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL iso_release: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL run_aw_ready: got %0d want %0d", got, exp); else n_pass++;
        idle();
    endtask

    // Port 1: fill reads to MaxTrans; the 9th waits for an R with last.
    task automatic test_rd_limit();
        slv_ar_valid_i[1] = 1'b1; mst_ar_ready_i[1] = 1'b1;
        for (int i = 0; i < MaxTrans; i++) begin
            exp_q.push_back(32'd1);
            #1;
            got = 32'(mst_ar_valid_o[1]); exp = exp_q.pop_front(); n_total++;
            if (got !== exp) $display("FAIL ar_fill[%0d]: got %0d want %0d", i, got, exp); else n_pass++;
            tick();
        end
        exp_q.push_back(32'd0);
        got = 32'(mst_ar_valid_o[1]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ar_9th_block: got %0d want %0d", got, exp); else n_pass++;
        tick();
        r_valid_i[1] = 1'b1; r_ready_i[1] = 1'b1; r_last_i[1] = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        got = 32'(mst_ar_valid_o[1]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ar_block_during_r: got %0d want %0d", got, exp); else n_pass++;
        tick();
        r_valid_i[1] = 1'b0; r_ready_i[1] = 1'b0; r_last_i[1] = 1'b0;
        exp_q.push_back(32'd1);
        got = 32'(mst_ar_valid_o[1]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ar_9th_pass: got %0d want %0d", got, exp); else n_pass++;
        tick();
        // R beat without last must not free a slot.
        r_valid_i[1] = 1'b1; r_ready_i[1] = 1'b1;
        tick();
        r_valid_i[1] = 1'b0; r_ready_i[1] = 1'b0;
        exp_q.push_back(32'd0);
        #1;
        got = 32'(mst_ar_valid_o[1]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL r_nolast_ignored: got %0d want %0d", got, exp); else n_pass++;
        slv_ar_valid_i[1] = 1'b0;
        r_valid_i[1] = 1'b1; r_ready_i[1] = 1'b1; r_last_i[1] = 1'b1;
        repeat (MaxTrans) tick();
        idle();
    endtask

    // Port 0: AW and B together at count 5 leaves 5; three more fill it.
    task automatic test_wr_same_cycle();
        slv_aw_valid_i[0] = 1'b1; mst_aw_ready_i[0] = 1'b1;
        repeat (5) tick();
        b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
        exp_q.push_back(32'd1);
        #1;
        got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL aw_b_same: got %0d want %0d", got, exp); else n_pass++;
        tick();
        b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'd1);
            #1;
            got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
            if (got !== exp) $display("FAIL aw_to_max[%0d]: got %0d want %0d", i, got, exp); else n_pass++;
            tick();
        end
        exp_q.push_back(32'd0);
        got = 32'(slv_aw_ready_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL aw_full_at_8: got %0d want %0d", got, exp); else n_pass++;
        slv_aw_valid_i[0] = 1'b0;
        b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
        repeat (MaxTrans) tick();
        idle();
    endtask

    // Port 1: spurious B at count 0 must leave the counter at 0.
    task automatic test_underflow();
        b_valid_i[1] = 1'b1; b_ready_i[1] = 1'b1;
        tick();
        b_valid_i[1] = 1'b0; b_ready_i[1] = 1'b0;
        slv_aw_valid_i[1] = 1'b1; mst_aw_ready_i[1] = 1'b1;
        for (int i = 0; i < MaxTrans; i++) begin
            exp_q.push_back(32'd1);
            #1;
            got = 32'(slv_aw_ready_o[1]); exp = exp_q.pop_front(); n_total++;
            if (got !== exp) $display("FAIL uf_aw_fill[%0d]: got %0d want %0d", i, got, exp); else n_pass++;
            tick();
        end
        exp_q.push_back(32'd0);
        got = 32'(slv_aw_ready_o[1]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL uf_aw_full: got %0d want %0d", got, exp); else n_pass++;
        slv_aw_valid_i[1] = 1'b0;
        b_valid_i[1] = 1'b1; b_ready_i[1] = 1'b1;
        repeat (MaxTrans) tick();
        idle();
    endtask

    task automatic test_ecc();
        ecc_error_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 14 || i == 19) begin
                exp_q.push_back((i + 1 > 15) ? 32'd15 : 32'(i + 1));
                got = 32'(ecc_count_o); exp = exp_q.pop_front(); n_total++;
                if (got !== exp) $display("FAIL ecc_count[%0d]: got %0d want %0d", i, got, exp); else n_pass++;
            end
        end
        ecc_clear_i = 1'b1;
        tick();
        exp_q.push_back(32'd1);
        got = 32'(ecc_count_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ecc_clear_with_err: got %0d want %0d", got, exp); else n_pass++;
        ecc_error_i = 1'b0;
        tick();
        exp_q.push_back(32'd0);
        got = 32'(ecc_count_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ecc_clear: got %0d want %0d", got, exp); else n_pass++;
        idle();
    endtask

    // Port 0: one write never answered while isolation is requested.
    task automatic test_timeout();
        slv_aw_valid_i[0] = 1'b1; mst_aw_ready_i[0] = 1'b1;
        tick();
        slv_aw_valid_i[0] = 1'b0; mst_aw_ready_i[0] = 1'b0;
        isolate_i[0] = 1'b1;
        tick();
        repeat (TimeoutCycles - 1) tick();
        exp_q.push_back(32'd0);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL to_not_yet: got %0d want %0d", got, exp); else n_pass++;
        tick();
`ifdef L2_ISOLATE_TIMEOUT_EN
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL to_isolated: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(timeout_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL to_flag: got %0d want %0d", got, exp); else n_pass++;
        isolate_i[0] = 1'b0;
        tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL to_release: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(timeout_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL to_flag_clear: got %0d want %0d", got, exp); else n_pass++;
        b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
        tick();
`else
        repeat (4) tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL drain_waits: got %0d want %0d", got, exp); else n_pass++;
        got = 32'(timeout_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL no_timeout: got %0d want %0d", got, exp); else n_pass++;
        b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1;
        tick();
        b_valid_i[0] = 1'b0; b_ready_i[0] = 1'b0;
        tick();
        exp_q.push_back(32'd1);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL drain_complete: got %0d want %0d", got, exp); else n_pass++;
`endif
        idle();
        tick();
    endtask

    // Port 0: reset while draining two reads.
    task automatic test_reset_mid_drain();
        slv_ar_valid_i[0] = 1'b1; mst_ar_ready_i[0] = 1'b1;
        repeat (2) tick();
        slv_ar_valid_i[0] = 1'b0; mst_ar_ready_i[0] = 1'b0;
        isolate_i[0] = 1'b1; ecc_error_i = 1'b1;
        tick();
        ecc_error_i = 1'b0;
        tick();
        exp_q.push_back(32'd0);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL mid_drain: got %0d want %0d", got, exp); else n_pass++;
        #2;
        rst_ni = 1'b0;
        isolate_i[0] = 1'b0;
        exp_q.push_back(32'd0);
        #1;
        got = 32'(ecc_count_o); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rst_async_ecc: got %0d want %0d", got, exp); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        slv_ar_valid_i[0] = 1'b1;
        exp_q.push_back(32'd1);
        #1;
        got = 32'(mst_ar_valid_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL ar_after_rst: got %0d want %0d", got, exp); else n_pass++;
        slv_ar_valid_i[0] = 1'b0;
        isolate_i[0] = 1'b1;
        tick();
        tick();
        exp_q.push_back(32'd1);
        got = 32'(isolated_o[0]); exp = exp_q.pop_front(); n_total++;
        if (got !== exp) $display("FAIL rst_cnt_zero: got %0d want %0d", got, exp); else n_pass++;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_drain_isolate();
        test_rd_limit();
        test_wr_same_cycle();
        test_underflow();
        test_ecc();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
